// File: rtl/fp16_mul_arbiter_if.sv
// fp16_mul_arbiter_if: requester, multiplier and response signals.
// master = requesters/multiplier side, slave = arbiter side.
interface fp16_mul_arbiter_if #(
    parameter int N_REQ   = 4,
    parameter int MUL_LAT = 6
);
    localparam int IDW = $clog2(N_REQ);
    localparam int LW  = $clog2(MUL_LAT + 1);

    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [16*N_REQ-1:0] req_a;
    logic [16*N_REQ-1:0] req_b;
    logic [15:0]         mul_a;
    logic [15:0]         mul_b;
    logic [15:0]         mul_out;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [15:0]         rsp_data;
    logic [IDW-1:0]      rsp_id;
    logic [LW-1:0]       inflight;

    modport master (
        output req_valid, req_a, req_b, mul_out, rsp_ready,
        input  req_ready, mul_a, mul_b, rsp_valid, rsp_data,
        input  rsp_id, inflight
    );

    modport slave (
        input  req_valid, req_a, req_b, mul_out, rsp_ready,
        output req_ready, mul_a, mul_b, rsp_valid, rsp_data,
        output rsp_id, inflight
    );
endinterface

// File: rtl/fp16_mul_arbiter.sv
// fp16_mul_arbiter: shares one pipelined fp16 multiplier among N_REQ
// requesters. Ports: clk, rst (sync, active-high), bus (slave modport:
// req_valid/ready/a/b, mul_a/b/out, rsp_valid/ready/data/id, inflight).
// Define FP16_ARB_RR_EN for round-robin grant; default is fixed priority.
module fp16_mul_arbiter #(
    parameter int N_REQ      = 4,
    parameter int MUL_LAT    = 6,
    parameter int FIFO_DEPTH = 8
) (
    input logic clk,
    input logic rst,
    fp16_mul_arbiter_if.slave bus
);
    localparam int IDW = $clog2(N_REQ);
    localparam int LW  = $clog2(MUL_LAT + 1);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int SW  = MUL_LAT * IDW;

    typedef struct packed {
        logic [15:0]    data;
        logic [IDW-1:0] id;
    } rsp_t;

    logic [LW-1:0]               inflight_q;
    logic [CW-1:0]               fifo_cnt;
    logic [PW-1:0]               wr_ptr;
    logic [PW-1:0]               rd_ptr;
    rsp_t                        fifo_mem [FIFO_DEPTH];
    logic [MUL_LAT-1:0]          sh_v;
    logic [MUL_LAT-1:0][IDW-1:0] sh_id;

    logic           credit_ok;
    logic           gnt_found;
    logic           issue;
    logic           push;
    logic           pop;
    logic           rsp_vld;
    logic [IDW-1:0] gnt_id;
    logic [IDW-1:0] start_id;

    // Registered occupancy only: a pop this cycle frees credit next cycle.
    assign credit_ok =
        (int'(fifo_cnt) + int'(inflight_q)) < FIFO_DEPTH;

`ifdef FP16_ARB_RR_EN
    logic [IDW-1:0] rr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= IDW'(N_REQ - 1);
        end else if (issue) begin
            rr_ptr <= gnt_id;
        end
    end

    assign start_id = (int'(rr_ptr) == N_REQ - 1) ?
                      '0 : rr_ptr + IDW'(1);
`else
    assign start_id = '0;
`endif

    // Scan from start_id, wrapping at N_REQ; first valid wins.
    always_comb begin
        int             s;
        logic [IDW-1:0] idx;
        gnt_found = 1'b0;
        gnt_id    = '0;
        s         = 0;
        idx       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            s = int'(start_id) + k;
            if (s >= N_REQ) begin
                s = s - N_REQ;
            end
            idx = IDW'(s);
            if (!gnt_found && credit_ok && !rst &&
                bus.req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_id    = idx;
            end
        end
    end

    assign issue = gnt_found;

    always_comb begin
        bus.req_ready = '0;
        if (gnt_found) begin
            bus.req_ready[gnt_id] = 1'b1;
        end
    end

    assign bus.mul_a = issue ?
        bus.req_a[{gnt_id, 4'b0000} +: 16] : 16'h0000;
    assign bus.mul_b = issue ?
        bus.req_b[{gnt_id, 4'b0000} +: 16] : 16'h0000;

    // Shadow pipeline mirrors the multiplier; the top bit falls off.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_v       <= '0;
            inflight_q <= '0;
        end else begin
            sh_v       <= MUL_LAT'({sh_v, issue});
            inflight_q <= inflight_q + LW'(issue)
                        - LW'(sh_v[MUL_LAT-1]);
        end
    end

    always_ff @(posedge clk) begin
        sh_id <= SW'({sh_id, gnt_id});
    end

    assign push = sh_v[MUL_LAT-1];
    assign pop  = rsp_vld && bus.rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{data: bus.mul_out,
                                  id:   sh_id[MUL_LAT-1]};
        end
    end

    assign rsp_vld       = !rst && (fifo_cnt != '0);
    assign bus.rsp_valid = rsp_vld;
    assign bus.rsp_data  = rsp_vld ? fifo_mem[rd_ptr].data : '0;
    assign bus.rsp_id    = rsp_vld ? fifo_mem[rd_ptr].id : '0;
    assign bus.inflight  = rst ? '0 : inflight_q;
endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// tb_fp16_mul_arbiter: directed bench with a behavioural fp16
// multiplier pipeline and an in-order response scoreboard.
module tb_fp16_mul_arbiter;
    localparam int N = 4;
    localparam int L = 6;
    localparam int D = 8;
`ifdef FP16_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    bit   mon_en;
    int   exp_q [$];

    logic [15:0] b_tab [N];
    logic [15:0] mpipe [L];

    fp16_mul_arbiter_if #(.N_REQ(N), .MUL_LAT(L)) bus ();

    fp16_mul_arbiter #(
        .N_REQ(N), .MUL_LAT(L), .FIFO_DEPTH(D)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] fmul(
        input logic [15:0] a, input logic [15:0] b);
        logic        s;
        logic [21:0] p;
        logic [9:0]  m;
        int          e;
        s = a[15] ^ b[15];
        if (a[14:0] == '0 || b[14:0] == '0) return {s, 15'd0};
        p = {11'd0, 1'b1, a[9:0]} * {11'd0, 1'b1, b[9:0]};
        e = int'(a[14:10]) + int'(b[14:10]) - 15;
        if (p[21]) begin
            m = p[20:11];
            e = e + 1;
        end else begin
            m = p[19:10];
        end
        return {s, e[4:0], m};
    endfunction

    always @(posedge clk) begin
        mpipe[0] <= fmul(bus.mul_a, bus.mul_b);
        for (int i = 1; i < L; i++) mpipe[i] <= mpipe[i-1];
    end
    assign bus.mul_out = mpipe[L-1];

    task automatic check(input string tag,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_g(input int k);
        return RR ? (k % N) : 0;
    endfunction

    // Scoreboard: every accepted response must match the issue order.
    always @(negedge clk) begin
        if (mon_en && bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("rsp_extra", 32'(bus.rsp_id), 32'hFFFF);
            end else begin
                int g;
                g = exp_q.pop_front();
                check("rsp_id", 32'(bus.rsp_id), 32'(g));
                check("rsp_data", 32'(bus.rsp_data),
                      32'(b_tab[g]));
            end
        end
    end

    task automatic do_reset();
        mon_en        = 1'b0;
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        exp_q.delete();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        tick();
        check("drain_empty", 32'(bus.rsp_valid), 32'd0);
    endtask

    task automatic single_op(input int id,
                             input logic [15:0] a,
                             input logic [15:0] b,
                             input logic [15:0] p);
        int lat;
        bus.rsp_ready           = 1'b1;
        bus.req_a[16*id +: 16]  = a;
        bus.req_b[16*id +: 16]  = b;
        bus.req_valid           = '0;
        bus.req_valid[id]       = 1'b1;
        #1;
        check("op_rdy", 32'(bus.req_ready), 32'(1 << id));
        check("op_mula", 32'(bus.mul_a), 32'(a));
        check("op_mulb", 32'(bus.mul_b), 32'(b));
        tick();
        bus.req_valid = '0;
        #1;
        check("op_infl", 32'(bus.inflight), 32'd1);
        lat = 1;
        while (!bus.rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("op_lat", 32'(lat), 32'd7);
        check("op_data", 32'(bus.rsp_data), 32'(p));
        check("op_id", 32'(bus.rsp_id), 32'(id));
        tick();
        check("op_pop", 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        mon_en   = 1'b0;
        b_tab[0] = 16'h3C00;
        b_tab[1] = 16'h4000;
        b_tab[2] = 16'h4200;
        b_tab[3] = 16'h4400;

        rst           = 1'b1;
        bus.req_valid = '1;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        tick();
        tick();
        check("rst_rdy", 32'(bus.req_ready), 32'd0);
        check("rst_mula", 32'(bus.mul_a), 32'd0);
        check("rst_mulb", 32'(bus.mul_b), 32'd0);
        check("rst_rvld", 32'(bus.rsp_valid), 32'd0);
        check("rst_rdat", 32'(bus.rsp_data), 32'd0);
        check("rst_rid", 32'(bus.rsp_id), 32'd0);
        check("rst_infl", 32'(bus.inflight), 32'd0);
        rst           = 1'b0;
        bus.req_valid = '0;
        tick();

        single_op(0, 16'h3C00, 16'h4000, 16'h4000);
        single_op(2, 16'h4200, 16'hC000, 16'hC600);

        // Contention: everyone valid, responses drained every cycle.
        do_reset();
        for (int i = 0; i < N; i++) begin
            bus.req_a[16*i +: 16] = 16'h3C00;
            bus.req_b[16*i +: 16] = b_tab[i];
        end
        mon_en        = 1'b1;
        bus.rsp_ready = 1'b1;
        bus.req_valid = '1;
        for (int k = 0; k < 16; k++) begin
            int g;
            #1;
            g = exp_g(k);
            check("ctn_rdy", 32'(bus.req_ready), 32'(1 << g));
            check("ctn_mulb", 32'(bus.mul_b), 32'(b_tab[g]));
            exp_q.push_back(g);
            if (k >= 7) begin
                check("ctn_infl", 32'(bus.inflight), 32'd6);
                check("ctn_fcnt", 32'(dut.fifo_cnt), 32'd1);
            end
            tick();
        end
        bus.req_valid = '0;
        drain();

        // Backpressure: credit caps outstanding work at D.
        do_reset();
        mon_en        = 1'b1;
        bus.req_valid = '1;
        for (int k = 0; k < 16; k++) begin
            #1;
            if (k < D) begin
                check("bp_rdy", 32'(bus.req_ready),
                      32'(1 << exp_g(k)));
                exp_q.push_back(exp_g(k));
            end else begin
                check("bp_stall", 32'(bus.req_ready), 32'd0);
            end
            tick();
        end
        check("bp_infl", 32'(bus.inflight), 32'd0);
        check("bp_fcnt", 32'(dut.fifo_cnt), 32'(D));
        check("bp_rvld", 32'(bus.rsp_valid), 32'd1);
        bus.rsp_ready = 1'b1;
        #1;
        check("bp_hold", 32'(bus.req_ready), 32'd0);
        tick();
        check("bp_resume", 32'(bus.req_ready),
              32'(1 << exp_g(D)));
        exp_q.push_back(exp_g(D));
        tick();
        bus.req_valid = '0;
        drain();

        // Reset with 6 in flight and 2 queued.
        do_reset();
        bus.req_valid = '1;
        repeat (D) tick();
        check("mid_infl", 32'(bus.inflight), 32'd6);
        check("mid_fcnt", 32'(dut.fifo_cnt), 32'd2);
        check("mid_rdy", 32'(bus.req_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("mid_rst_rvld", 32'(bus.rsp_valid), 32'd0);
        check("mid_rst_infl", 32'(bus.inflight), 32'd0);
        check("mid_rst_rdy", 32'(bus.req_ready), 32'd0);
        tick();
        rst           = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("post_rvld", 32'(bus.rsp_valid), 32'd0);
            check("post_infl", 32'(bus.inflight), 32'd0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
